// File: rtl/sprite_compositor.sv
// sprite_compositor: pipelined sprite hit test, ROM addressing and transparency keying.
// Holds NUM_SLOTS double-buffered descriptors (shadow written any time, active set
// updated on frame_start) plus per-slot animation frame counters.
// Pipeline: stage 1 hit test, stage 2 ROM address, stage 3 texel keying. The ROM
// answers one cycle after rom_addr, so color/draw are formed from rom_data and
// stage-3 registers, giving out_valid three cycles after pix_valid.
// Optional feature: define SPRITE_COMPOSITOR_FLIP_EN to add wr_flip and a per-slot
// horizontal mirror.
module sprite_compositor #(
  parameter int NUM_SLOTS  = 8,
  parameter int SPR_W      = 45,
  parameter int SPR_H      = 70,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int ROM_AW     = 16,
  parameter int TRANSP_KEY = 63
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
  input  logic [10:0]                  wr_x,
  input  logic [10:0]                  wr_y,
  input  logic                         wr_enable,
  input  logic                         wr_anim,
  input  logic [ROM_AW-1:0]            wr_base,
`ifdef SPRITE_COMPOSITOR_FLIP_EN
  input  logic                         wr_flip,
`endif
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [10:0]                  vga_x,
  input  logic [10:0]                  vga_y,
  output logic [ROM_AW-1:0]            rom_addr,
  input  logic [5:0]                   rom_data,
  output logic                         out_valid,
  output logic [5:0]                   color,
  output logic                         draw,
  output logic [$clog2(NUM_SLOTS)-1:0] hit_slot
);

  localparam int SW       = $clog2(NUM_SLOTS);
  localparam int FW       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int LXW      = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int LYW      = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  typedef struct packed {
    logic [10:0]       x;
    logic [10:0]       y;
    logic              en;
    logic              anim;
    logic [ROM_AW-1:0] base;
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    logic              flip;
`endif
  } desc_t;

  desc_t             sh_q  [NUM_SLOTS];
  desc_t             act_q [NUM_SLOTS];
  desc_t             wr_desc_d;
  logic [FW-1:0]     frame_q [NUM_SLOTS];
  logic [DW-1:0]     div_q;
  logic              wrap_d;

  logic [NUM_SLOTS-1:0] slot_hit_d;
  logic                 any_hit_d;
  logic [SW-1:0]        sel_d;
  logic [LXW-1:0]       lx_d;
  logic [LYW-1:0]       ly_d;

  logic                 s1_valid_q, s1_hit_q;
  logic [SW-1:0]        s1_slot_q;
  logic [LXW-1:0]       s1_lx_q;
  logic [LYW-1:0]       s1_ly_q;

  logic [31:0]          lx_eff_d;
  logic [ROM_AW-1:0]    addr_d;
  logic                 s2_valid_q, s2_hit_q;
  logic [SW-1:0]        s2_slot_q;
  logic [ROM_AW-1:0]    rom_addr_q;

  logic                 s3_valid_q, s3_hit_q;
  logic [SW-1:0]        s3_slot_q;

  // Pack the write-port fields into one descriptor word.
  always_comb begin
    wr_desc_d      = '0;
    wr_desc_d.x    = wr_x;
    wr_desc_d.y    = wr_y;
    wr_desc_d.en   = wr_enable;
    wr_desc_d.anim = wr_anim;
    wr_desc_d.base = wr_base;
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    wr_desc_d.flip = wr_flip;
`endif
  end

  // Shadow/active descriptor banks; a same-cycle write is forwarded into the copy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && (wr_slot == SW'(i))) begin
          sh_q[i] <= wr_desc_d;
        end
        if (frame_start) begin
          act_q[i] <= (wr_en && (wr_slot == SW'(i))) ? wr_desc_d : sh_q[i];
        end
      end
    end
  end

  assign wrap_d = frame_start && (div_q == DW'(FRAME_DIV - 1));

  // Frame divider and per-slot animation counters; a slot write restarts its animation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        div_q <= wrap_d ? '0 : div_q + 1'b1;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && (wr_slot == SW'(i))) begin
          frame_q[i] <= '0;
        end else if (wrap_d && act_q[i].anim) begin
          frame_q[i] <= (frame_q[i] == FW'(NUM_FRAMES - 1)) ? '0 : frame_q[i] + 1'b1;
        end
      end
    end
  end

  // Per-slot box test in 12 bits so boxes near the right/bottom edge clip instead of wrapping.
  always_comb begin
    slot_hit_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_hit_d[i] = act_q[i].en
        && ({1'b0, vga_x} >= {1'b0, act_q[i].x})
        && ({1'b0, vga_x} <  ({1'b0, act_q[i].x} + 12'(SPR_W)))
        && ({1'b0, vga_y} >= {1'b0, act_q[i].y})
        && ({1'b0, vga_y} <  ({1'b0, act_q[i].y} + 12'(SPR_H)));
    end
  end

  // Priority encoder: scanning downwards leaves the lowest-index hitting slot selected.
  always_comb begin
    any_hit_d = |slot_hit_d;
    sel_d     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      sel_d = slot_hit_d[i] ? SW'(i) : sel_d;
    end
    lx_d = LXW'(vga_x - act_q[sel_d].x);
    ly_d = LYW'(vga_y - act_q[sel_d].y);
  end

  // Stage 1: latch hit result and local coordinates only for valid pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_slot_q  <= '0;
      s1_lx_q    <= '0;
      s1_ly_q    <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      if (pix_valid) begin
        s1_hit_q  <= any_hit_d;
        s1_slot_q <= sel_d;
        s1_lx_q   <= lx_d;
        s1_ly_q   <= ly_d;
      end
    end
  end

  // Texel address from registered stage-1 state; mirrored column when flip is set.
  always_comb begin
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    if (act_q[s1_slot_q].flip) begin
      lx_eff_d = 32'(SPR_W - 1) - 32'(s1_lx_q);
    end else begin
      lx_eff_d = 32'(s1_lx_q);
    end
`else
    lx_eff_d = 32'(s1_lx_q);
`endif
    addr_d = ROM_AW'(32'(act_q[s1_slot_q].base)
                   + 32'(frame_q[s1_slot_q]) * 32'(FRAME_SZ)
                   + 32'(s1_ly_q) * 32'(SPR_W)
                   + lx_eff_d);
  end

  // Stage 2: register ROM address (held on a miss) and forward hit state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_slot_q  <= '0;
      rom_addr_q <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_valid_q && s1_hit_q;
      s2_slot_q  <= s1_slot_q;
      if (s1_valid_q && s1_hit_q) begin
        rom_addr_q <= addr_d;
      end
    end
  end

  // Stage 3: align hit state with the texel the ROM returns this cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s3_valid_q <= 1'b0;
      s3_hit_q   <= 1'b0;
      s3_slot_q  <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_hit_q   <= s2_hit_q;
      s3_slot_q  <= s2_hit_q ? s2_slot_q : '0;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = s3_valid_q;
  assign hit_slot  = s3_slot_q;
  assign color     = s3_hit_q ? rom_data : 6'd0;
  assign draw      = s3_hit_q && (rom_data != 6'(TRANSP_KEY));

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: a reference model predicts every
// pixel result at drive time, pushes it to a queue, and a monitor pops and
// compares it when out_valid appears.
module tb_sprite_compositor;
  localparam int NS = 8;
  localparam int SW = 45;
  localparam int SH = 70;
  localparam int NF = 4;
  localparam int FD = 8;
  localparam int AW = 16;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_slot = 3'd0;
  logic [10:0]     wr_x = 11'd0, wr_y = 11'd0;
  logic            wr_enable = 1'b0, wr_anim = 1'b0;
  logic [AW-1:0]   wr_base = 16'd0;
`ifdef SPRITE_COMPOSITOR_FLIP_EN
  logic            wr_flip = 1'b0;
`endif
  logic            frame_start = 1'b0, pix_valid = 1'b0;
  logic [10:0]     vga_x = 11'd0, vga_y = 11'd0;
  logic [AW-1:0]   rom_addr;
  logic [5:0]      rom_data = 6'd0;
  logic            out_valid, draw;
  logic [5:0]      color;
  logic [2:0]      hit_slot;

  always #5 Clk = ~Clk;

  sprite_compositor #(.NUM_SLOTS(NS), .SPR_W(SW), .SPR_H(SH), .NUM_FRAMES(NF),
                      .FRAME_DIV(FD), .ROM_AW(AW), .TRANSP_KEY(63)) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y),
    .wr_enable(wr_enable), .wr_anim(wr_anim), .wr_base(wr_base),
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    .wr_flip(wr_flip),
`endif
    .frame_start(frame_start), .pix_valid(pix_valid), .vga_x(vga_x), .vga_y(vga_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid), .color(color),
    .draw(draw), .hit_slot(hit_slot));

  // Sprite ROM model: synchronous read, optional forced texel value.
  bit       rom_ovr_en = 1'b0;
  bit [5:0] rom_ovr = 6'd0;
  function automatic logic [5:0] rom_fn(input logic [AW-1:0] a);
    return rom_ovr_en ? rom_ovr : 6'(a % 16'd62);
  endfunction
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct { bit [10:0] x; bit [10:0] y; bit en; bit anim; bit flip; bit [15:0] base; } d_t;
  typedef struct { int cyc; bit hit; int slot; bit [15:0] addr; bit [5:0] color; bit draw; } exp_t;
  d_t   m_sh [NS];
  d_t   m_act [NS];
  int   m_frame [NS];
  int   m_div;
  exp_t q[$];

  function automatic exp_t model_pix(input int x, input int y);
    exp_t e;
    int lx, ly, a;
    e.cyc = cyc; e.hit = 1'b0; e.slot = 0; e.addr = 16'd0; e.color = 6'd0; e.draw = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!e.hit && m_act[s].en && x >= int'(m_act[s].x) && x < int'(m_act[s].x) + SW
          && y >= int'(m_act[s].y) && y < int'(m_act[s].y) + SH) begin
        e.hit = 1'b1;
        e.slot = s;
      end
    end
    if (e.hit) begin
      lx = x - int'(m_act[e.slot].x);
      ly = y - int'(m_act[e.slot].y);
      if (m_act[e.slot].flip) lx = SW - 1 - lx;
      a = int'(m_act[e.slot].base) + m_frame[e.slot] * SW * SH + ly * SW + lx;
      e.addr = a[15:0];
      e.color = rom_fn(e.addr);
      e.draw = (e.color != 6'd63);
    end
    return e;
  endfunction

  function automatic void model_advance();
    bit wrap;
    wrap = (m_div == FD - 1);
    m_div = (m_div + 1) % FD;
    if (wrap)
      for (int i = 0; i < NS; i++)
        if (m_act[i].anim) m_frame[i] = (m_frame[i] + 1) % NF;
  endfunction

  // Output monitor: pops the scoreboard and compares, away from the active edge.
  logic [AW-1:0] prev_addr = 16'd0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("latency", 32'(cyc), 32'(e.cyc + 3));
        check("draw", 32'(draw), 32'(e.draw));
        check("color", 32'(color), 32'(e.color));
        if (e.hit) begin
          check("hit_slot", 32'(hit_slot), 32'(e.slot));
          check("rom_addr", 32'(prev_addr), 32'(e.addr));
        end
      end
    end
    prev_addr = rom_addr;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    tick();
    pix_valid = 1'b1;
    vga_x = 11'(x);
    vga_y = 11'(y);
    q.push_back(model_pix(x, y));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      pix_valid = 1'b0;
    end
  endtask

  task automatic wr(input int s, input int x, input int y, input bit en, input bit anim,
                    input int base, input bit flip, input bit with_fs);
    tick();
    pix_valid = 1'b0;
    wr_en = 1'b1; wr_slot = 3'(s); wr_x = 11'(x); wr_y = 11'(y);
    wr_enable = en; wr_anim = anim; wr_base = 16'(base);
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    wr_flip = flip;
`endif
    frame_start = with_fs;
    if (with_fs) model_advance();
    m_sh[s].x = 11'(x); m_sh[s].y = 11'(y); m_sh[s].en = en; m_sh[s].anim = anim;
    m_sh[s].base = 16'(base);
`ifdef SPRITE_COMPOSITOR_FLIP_EN
    m_sh[s].flip = flip;
`else
    m_sh[s].flip = 1'b0 & flip;
`endif
    m_frame[s] = 0;
    if (with_fs) m_act = m_sh;
    tick();
    wr_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fs();
    tick();
    pix_valid = 1'b0;
    frame_start = 1'b1;
    model_advance();
    m_act = m_sh;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    Reset = 1'b1; pix_valid = 1'b0; wr_en = 1'b0; frame_start = 1'b0;
    q.delete();
    for (int i = 0; i < NS; i++) begin
      m_sh[i] = '{default: 0};
      m_act[i] = '{default: 0};
      m_frame[i] = 0;
    end
    m_div = 0;
    tick();
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    tick();
    Reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_hit_slot", 32'(hit_slot), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and an empty-scene pixel.
    do_reset();
    pix(0, 0);
    idle(6);

    // Single slot, corners and just-outside edges.
    wr(0, 100, 50, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    fs();
    pix(100, 50);
    pix(144, 119);
    pix(145, 50);
    pix(100, 120);
    pix(99, 50);
    pix(100, 49);
    for (int x = 95; x < 150; x++) pix(x, 60);
    idle(6);

    // Double buffering: mid-frame write stays invisible until frame_start.
    wr(0, 300, 50, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    pix(100, 50);
    pix(300, 50);
    idle(6);
    fs();
    pix(100, 50);
    pix(300, 50);
    idle(6);
    // Write coinciding with frame_start is visible immediately.
    wr(5, 800, 400, 1'b1, 1'b0, 9000, 1'b0, 1'b1);
    pix(810, 410);
    idle(6);

    // Priority, transparency and right/bottom clipping.
    wr(0, 170, 160, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    wr(3, 200, 200, 1'b1, 1'b0, 5000, 1'b0, 1'b0);
    wr(7, 2030, 2000, 1'b1, 1'b0, 20000, 1'b0, 1'b0);
    fs();
    rom_ovr_en = 1'b1;
    rom_ovr = 6'd63;
    pix(200, 200);
    pix(240, 260);
    idle(6);
    rom_ovr = 6'd12;
    pix(200, 200);
    pix(240, 260);
    pix(2047, 2047);
    idle(6);
    rom_ovr_en = 1'b0;

    // Random pixels with gaps against the current scene.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      pix(int'($urandom_range(0, 900)), int'($urandom_range(0, 500)));
    end
    idle(6);

    // Mid-line reset flushes the pipeline.
    pix(210, 210);
    pix(211, 210);
    do_reset();
    idle(4);

    // Animation: slot 0 runs, slot 1 holds.
    wr(0, 400, 300, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    wr(1, 600, 300, 1'b1, 1'b0, 1000, 1'b0, 1'b0);
    repeat (8) fs();
    pix(400, 300);
    idle(6);
    check("anim_after_8", 32'(rom_addr), 32'd3150);
    pix(600, 300);
    idle(6);
    check("anim_hold", 32'(rom_addr), 32'd1000);
    repeat (24) fs();
    pix(400, 301);
    idle(6);
    check("anim_wrap_32", 32'(rom_addr), 32'd45);

`ifdef SPRITE_COMPOSITOR_FLIP_EN
    // Horizontal mirror.
    wr(2, 500, 100, 1'b1, 1'b0, 7000, 1'b1, 1'b0);
    fs();
    pix(500, 100);
    idle(6);
    check("flip_lx0", 32'(rom_addr), 32'd7044);
`endif

    idle(6);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined replacement for the per-sprite combinational hit logic.
- Holds NUM_SLOTS sprite descriptors. For each incoming VGA pixel it picks the highest-priority slot whose box covers the pixel, fetches the texel from a shared sprite ROM and applies the transparency key.
- Outputs color/draw with fixed latency; downstream muxing against the background happens there.
- Adds double-buffered descriptors, per-slot animation counters and a registered ROM interface.

Parameters:
- NUM_SLOTS, 8: sprite slots; slot 0 has highest priority.
- SPR_W, 45: sprite width in pixels.
- SPR_H, 70: sprite height in pixels.
- NUM_FRAMES, 4: animation frames per sprite, power of two.
- FRAME_DIV, 8: video frames per animation step.
- ROM_AW, 16: sprite ROM address width.
- TRANSP_KEY, 63: 6-bit color treated as transparent.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- wr_en  in  1  descriptor write strobe.
- wr_slot  in  $clog2(NUM_SLOTS)  slot index to write.
- wr_x, wr_y  in  11 each  top-left corner of the sprite.
- wr_enable  in  1  slot visible.
- wr_anim  in  1  animation counter runs.
- wr_base  in  ROM_AW  ROM base address of frame 0.
- frame_start  in  1  one-cycle pulse at vertical blank.
- pix_valid  in  1  vga_x/vga_y valid this cycle.
- vga_x, vga_y  in  11 each  pixel coordinate.
- rom_addr  out  ROM_AW  registered ROM address.
- rom_data  in  6  ROM texel, valid exactly one cycle after rom_addr.
- out_valid  out  1  color/draw/hit_slot valid.
- color  out  6  texel color.
- draw  out  1  opaque sprite pixel present.
- hit_slot  out  $clog2(NUM_SLOTS)  winning slot.

Behaviour:
- Single clock domain, Clk. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - All shadow and active descriptors cleared (enable=0).
  - Animation frame counters 0; FRAME_DIV divider 0.
- Descriptors:
  - wr_en writes the shadow copy of wr_slot.
  - On frame_start, all shadow descriptors copy to the active set in one cycle.
  - wr_en together with frame_start on the same slot: the new value goes to shadow first, then that value is copied to active (the write is visible this frame).
  - Writes never alter the active set mid-frame.
- Animation:
  - The divider counts frame_start pulses.
  - On the pulse that wraps the divider (FRAME_DIV-1 -> 0), every active slot with anim=1 advances frame = (frame+1) mod NUM_FRAMES.
  - anim=0 holds the frame counter at its current value.
  - Writing a slot resets its frame counter to 0.
- Stage 1 (hit test, registered):
  - A slot hits iff enable && x <= vga_x < x+SPR_W && y <= vga_y < y+SPR_H.
  - Sums are computed in 12 bits so no wrap occurs; x+SPR_W > 2047 simply clips.
  - Priority encoder selects the lowest-index hitting slot.
  - Latch hit flag, slot index, lx = vga_x - x, ly = vga_y - y.
  - Nothing is latched when pix_valid=0; the valid bit propagates as 0.
- Stage 2 (address):
  - rom_addr = base + frame*SPR_W*SPR_H + ly*SPR_W + lx, truncated to ROM_AW.
  - The multiply by a constant is synthesised as shift-add or DSP; no combinational path from vga_x to rom_addr.
  - rom_addr holds its last value on a miss.
- Stage 3 (output):
  - color = rom_data; draw = hit && (rom_data != TRANSP_KEY); hit_slot registered.
  - On a miss: draw=0, color=0.
- Latency: pix_valid at cycle N -> out_valid at cycle N+3, fully pipelined, one pixel per cycle, no stalls.
- Transparency does not fall through to lower-priority slots: a transparent texel on the winning slot yields draw=0.
- Reset mid-line: the pipeline flushes; out_valid=0 starting the cycle after Reset.

Optional Feature:
- Macro: SPRITE_COMPOSITOR_FLIP_EN.
- Defined:
  - Adds input wr_flip (1 bit) and a per-slot flip bit, double-buffered like the other descriptor fields.
  - When flip=1, stage 2 uses SPR_W-1-lx in place of lx (horizontal mirror).
- Undefined: no wr_flip port; addressing as above.

Test Plan:
- Reset: assert Reset for 2 cycles -> all outputs 0; a pixel at (0,0) gives draw=0 at N+3.
- Single slot and edges:
  - Stimulus: slot0 x=100 y=50 base=0 enabled; frame_start; pixel (100,50).
  - Required: rom_addr=0 at N+2, out_valid=1 at N+3.
  - Pixels (144,119) hit; (145,50) and (100,120) miss.
- Priority and transparency:
  - Stimulus: slots 0 and 3 overlap at (200,200).
  - Required: hit_slot=0; rom_data=63 gives draw=0; rom_data=12 gives draw=1, color=12.
- Double buffer: wr_en moves slot0 to x=300 mid-frame -> pixel at old position still hits until the next frame_start, then misses.
- Animation:
  - Stimulus: anim=1, FRAME_DIV=8, base=0.
  - Required: after 8 frame_start pulses, pixel (x,y) gives rom_addr=3150; after 32 pulses the frame wraps to 0.
- Flip (macro defined): flip=1, pixel at lx=0 -> rom_addr = base+44.
